alu_share_arbiter: RTL

//  Shares the single ArithmeticLogicUnit between NUM_REQ requesters (execute stage, address calc, debug port).

---
 rtl/alu_share_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between NUM_REQ requesters.
// Operands and results are registered; one operation is in flight at a time.
module alu_share_arbiter #(
    parameter int         NUM_REQ = 2,
    parameter int         WIDTH   = 16,
    parameter logic [1:0] A_TYPE  = 2'b00,
    localparam int        ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_rn,
    input  logic [NUM_REQ*WIDTH-1:0] req_rm,
    input  logic [NUM_REQ*WIDTH-1:0] req_instr,
    output logic [WIDTH-1:0]         alu_rn,
    output logic [WIDTH-1:0]         alu_rm,
    output logic [WIDTH-1:0]         alu_instr,
    input  logic [WIDTH-1:0]         alu_rd,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_data,
    output logic                     resp_err,
    output logic [15:0]              ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_reg;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [WIDTH-1:0]  alu_rn_reg;
    logic [WIDTH-1:0]  alu_rm_reg;
    logic [WIDTH-1:0]  alu_instr_reg;
    logic [ID_W-1:0]   resp_id_reg;
    logic [WIDTH-1:0]  resp_data_reg;
    logic              resp_err_reg;
    logic [15:0]       ops_done_reg;

    logic              accept_ok;
    logic              gnt_valid;
    logic [ID_W-1:0]   gnt_idx;
    logic [ID_W-1:0]   rr_ptr_next;
    logic              resp_hs;

    logic [WIDTH-1:0]  rn_arr    [NUM_REQ];
    logic [WIDTH-1:0]  rm_arr    [NUM_REQ];
    logic [WIDTH-1:0]  instr_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign rn_arr[gi]    = req_rn[WIDTH*gi +: WIDTH];
            assign rm_arr[gi]    = req_rm[WIDTH*gi +: WIDTH];
            assign instr_arr[gi] = req_instr[WIDTH*gi +: WIDTH];
        end
    endgenerate

    assign resp_hs   = (state_reg == RESP) && resp_ready;
    assign accept_ok = (state_reg == IDLE) || resp_hs;

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        if (!reset && accept_ok) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!gnt_valid && req_valid[idx]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = ID_W'(idx);
                end
            end
        end
        if (gnt_valid) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign rr_ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            id_reg        <= '0;
            alu_rn_reg    <= '0;
            alu_rm_reg    <= '0;
            alu_instr_reg <= '0;
            resp_id_reg   <= '0;
            resp_data_reg <= '0;
            resp_err_reg  <= 1'b0;
            ops_done_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_reg <= alu_rd;
                    resp_err_reg  <= (alu_instr_reg[WIDTH-1 -: 2] != A_TYPE);
                    resp_id_reg   <= id_reg;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        ops_done_reg <= ops_done_reg + 16'd1;
                        state_reg    <= gnt_valid ? EXEC : IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase

            // Operands load only on a grant, so the ALU inputs stay quiet otherwise.
            if (gnt_valid) begin
                alu_rn_reg    <= rn_arr[gnt_idx];
                alu_rm_reg    <= rm_arr[gnt_idx];
                alu_instr_reg <= instr_arr[gnt_idx];
                id_reg        <= gnt_idx;
                rr_ptr_reg    <= rr_ptr_next;
            end
        end
    end

    assign alu_rn     = alu_rn_reg;
    assign alu_rm     = alu_rm_reg;
    assign alu_instr  = alu_instr_reg;
    assign resp_valid = (state_reg == RESP);
    assign resp_id    = resp_id_reg;
    assign resp_data  = resp_data_reg;
    assign resp_err   = resp_err_reg;
    assign ops_done   = ops_done_reg;

endmodule
